sequenciador_leds: RTL and testbench
====================================

# sequenciador_leds

Display sequencer for the memory game. On `iniciar` it walks the sequence RAM from address 0 up to a captured `limite`. For each entry it shows the stored LED pattern for `T_ON` cycles, then blanks the LEDs for `T_OFF` cycles. After the last entry it pulses `pronto`. It sits between the game's main control unit and the sequence RAM / LED outputs, and it replaces the inline show-LED / show-blank states of the main FSM.

## Interface
Parameters:
- `ADDR_W`, default 4: RAM address width; also the width of `limite`.
- `DATA_W`, default 4: LED pattern width.
- `T_ON`, default 500: cycles each pattern is lit; must be ≥1.
- `T_OFF`, default 250: cycles blank after each pattern; must be ≥1.

Ports:
- `clock`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-low reset.
- `iniciar`, in, 1: start request; sampled only in OCIOSO.
- `cancelar`, in, 1: abort; overrides everything except reset.
- `limite`, in, `ADDR_W`: last address to display; captured when start is accepted.
- `dado_mem`, in, `DATA_W`: RAM read data for `endereco`.
- `endereco`, out, `ADDR_W`: registered RAM address.
- `leds`, out, `DATA_W`: displayed pattern; 0 outside MOSTRA.
- `ocupado`, out, 1: high in every state except OCIOSO.
- `pronto`, out, 1: one-cycle pulse in FIM.
- `db_estado`, out, 3: current state code.

## Operation
- States and codes: OCIOSO=0, CARREGA=1, MOSTRA=2, APAGADO=3, PROXIMO=4, FIM=5, PAUSA=6 (PAUSA exists only with the macro).
- OCIOSO, `iniciar`=1: capture `limite` into `lim_r`, clear `endereco`, go to CARREGA (or PAUSA with the macro).
- CARREGA: one wait cycle for RAM data. At the exit edge, capture `dado_mem` into `led_r`, load the timer with `T_ON-1`, go to MOSTRA.
- MOSTRA: `leds`=`led_r`. Decrement the timer; at 0, load `T_OFF-1` and go to APAGADO.
- APAGADO: `leds`=0. Decrement the timer; at 0, go to PROXIMO.
- PROXIMO:
  - `endereco`==`lim_r` → FIM.
  - Otherwise `endereco`+1 → CARREGA.
- FIM: `pronto`=1 for exactly one cycle, then OCIOSO. `endereco` holds the last address.
- `cancelar`=1 in any non-OCIOSO state: next state is OCIOSO, `leds`=0, no `pronto`. In OCIOSO, `cancelar` has priority over `iniciar`.
- `iniciar` while `ocupado`=1 is ignored (no restart). Changes to `limite` mid-run are ignored.
- Timer width is `$clog2(max(T_ON,T_OFF))`, with a minimum of 1 bit. `endereco` never wraps, because PROXIMO stops at `lim_r`. With `lim_r` = 2^ADDR_W−1, the last address is shown and then FIM is entered with no overflow.

## Timing
- Reset (`reset`=0 at an edge) forces, from the next cycle:
  - State = OCIOSO.
  - `endereco`=0, `leds`=0, `ocupado`=0, `pronto`=0, `db_estado`=0.
  - `led_r`=0, timer=0, `lim_r`=0.
- Reset mid-run has the same effect; no `pronto` is produced.
- Let `iniciar` be sampled high in OCIOSO at cycle c. Then:
  - CARREGA for entry i starts at c+1+i·P, where P = T_ON+T_OFF+2.
  - `leds` is valid for cycles c+2+i·P through c+1+i·P+T_ON.
  - With n = `lim_r`+1 entries, FIM (the `pronto` pulse) occurs at cycle c+1+n·P.
- `dado_mem` must be stable by the end of the CARREGA cycle, i.e. one full cycle after `endereco` changes (combinational or same-cycle RAM read).
- `cancelar` sampled at cycle k: OCIOSO and `leds`=0 from cycle k+1.
- A new `iniciar` is accepted at the earliest in the cycle after FIM.

## Configuration
- `SEQ_PAUSA_INICIAL_EN` defined:
  - Accepting start goes OCIOSO→PAUSA.
  - PAUSA holds `leds`=0 for `T_OFF` cycles, then goes to CARREGA.
  - All timing above shifts by +`T_OFF` (FIM at c+1+T_OFF+n·P).
- Undefined: the PAUSA state and its logic are absent; code 6 is never produced.

## Test plan
All scenarios use T_ON=4, T_OFF=2, so P=8.
- **Reset values:** hold `reset`=0 for 2 cycles → all outputs 0, `db_estado`=0.
- **Normal run:** RAM = 1,2,4,8; `limite`=3; `iniciar` at c →
  - `leds` = 1 in c+2..c+5, 2 in c+10..c+13, 4 in c+18..c+21, 8 in c+26..c+29, 0 otherwise.
  - `pronto` is a single pulse at c+33; `ocupado` is high c+1..c+33.
- **Single entry:** `limite`=0, RAM[0]=4'b0010 → `leds`=2 in c+2..c+5, `pronto` at c+9, `endereco` stays 0.
- **Abort:** `cancelar` at c+12 in the normal run → `leds`=0 and `ocupado`=0 from c+13, no `pronto`. A fresh `iniciar` at c+20 then replays from address 0.
- **Ignored inputs:** `iniciar` re-pulsed at c+7 and `limite` changed to 1 at c+3 → the run is still 4 entries, `pronto` at c+33.
- **Macro build:** with `SEQ_PAUSA_INICIAL_EN`, normal run → first `leds`=1 at c+4, `pronto` at c+35, `db_estado`=6 in c+1..c+2.

Source files
------------

// File: rtl/sequenciador_leds.sv
// sequenciador_leds: display sequencer for the memory game.
// Walks the sequence RAM from address 0 up to a captured limit.
// Each entry is lit for T_ON cycles and then blanked for T_OFF cycles.
// After the last entry, pronto pulses for one cycle.
// Optional feature macro: SEQ_PAUSA_INICIAL_EN. When defined, a blank
// PAUSA of T_OFF cycles is inserted before the first entry.
// Handshake: iniciar is only looked at while idle (ocupado=0). A start is
// accepted in the cycle it is seen high and cancelar is low. pronto is a
// single-cycle completion strobe with no back-pressure. cancelar aborts
// any run on the next edge and produces no pronto.
module sequenciador_leds #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4,
    parameter int T_ON   = 500,
    parameter int T_OFF  = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              cancelar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_mem,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    // Timer must hold T_ON-1 and T_OFF-1; never narrower than one bit.
    localparam int T_MAX = (T_ON > T_OFF) ? T_ON : T_OFF;
    localparam int TW    = (T_MAX <= 2) ? 1 : $clog2(T_MAX);

`ifdef SEQ_PAUSA_INICIAL_EN
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        MOSTRA  = 3'd2,
        APAGADO = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5,
        PAUSA   = 3'd6
    } estado_t;
`else
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        MOSTRA  = 3'd2,
        APAGADO = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;
`endif

    estado_t           estado;
    estado_t           estado_prox;
    logic [TW-1:0]     timer;
    logic [DATA_W-1:0] led_r;
    logic [ADDR_W-1:0] lim_r;
    logic              timer_zero;
    logic              ultimo;

    assign timer_zero = (timer == '0);
    assign ultimo     = (endereco == lim_r);

    // State register; reset is synchronous and active-low.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Next-state decode and Moore outputs; cancelar wins over everything else.
    always_comb begin
        estado_prox = estado;
        leds        = '0;
        ocupado     = (estado != OCIOSO);
        pronto      = 1'b0;
        db_estado   = estado;
        if (cancelar) begin
            estado_prox = OCIOSO;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
`ifdef SEQ_PAUSA_INICIAL_EN
                        estado_prox = PAUSA;
`else
                        estado_prox = CARREGA;
`endif
                    end
                end
`ifdef SEQ_PAUSA_INICIAL_EN
                PAUSA: begin
                    if (timer_zero) estado_prox = CARREGA;
                end
`endif
                CARREGA: estado_prox = MOSTRA;
                MOSTRA: begin
                    if (timer_zero) estado_prox = APAGADO;
                end
                APAGADO: begin
                    if (timer_zero) estado_prox = PROXIMO;
                end
                PROXIMO: estado_prox = ultimo ? FIM : CARREGA;
                FIM:     estado_prox = OCIOSO;
                default: estado_prox = OCIOSO;
            endcase
        end
        if (estado == MOSTRA) leds = led_r;
        if (estado == FIM)    pronto = 1'b1;
    end

    // Datapath: limit capture, address walk, pattern latch and phase timer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            endereco <= '0;
            led_r    <= '0;
            timer    <= '0;
            lim_r    <= '0;
        end else if (!cancelar) begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        lim_r    <= limite;
                        endereco <= '0;
`ifdef SEQ_PAUSA_INICIAL_EN
                        timer    <= TW'(T_OFF - 1);
`endif
                    end
                end
`ifdef SEQ_PAUSA_INICIAL_EN
                PAUSA: begin
                    if (!timer_zero) timer <= timer - TW'(1);
                end
`endif
                CARREGA: begin
                    led_r <= dado_mem;
                    timer <= TW'(T_ON - 1);
                end
                MOSTRA: begin
                    if (timer_zero) timer <= TW'(T_OFF - 1);
                    else            timer <= timer - TW'(1);
                end
                APAGADO: begin
                    if (!timer_zero) timer <= timer - TW'(1);
                end
                PROXIMO: begin
                    if (!ultimo) endereco <= endereco + ADDR_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequenciador_leds.sv
// tb_sequenciador_leds: directed bench for sequenciador_leds (T_ON=4, T_OFF=2).
// Works with or without SEQ_PAUSA_INICIAL_EN defined; the pause shifts
// every expected time by T_OFF.
module tb_sequenciador_leds;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;
    localparam int T_ON   = 4;
    localparam int T_OFF  = 2;
    localparam int P      = T_ON + T_OFF + 2;
`ifdef SEQ_PAUSA_INICIAL_EN
    localparam int PS = T_OFF;
`else
    localparam int PS = 0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              iniciar;
    logic              cancelar;
    logic [ADDR_W-1:0] limite;
    logic [DATA_W-1:0] dado_mem;
    logic [ADDR_W-1:0] endereco;
    logic [DATA_W-1:0] leds;
    logic              ocupado;
    logic              pronto;
    logic [2:0]        db_estado;

    logic [DATA_W-1:0] ram [0:15];

    sequenciador_leds #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .T_ON(T_ON), .T_OFF(T_OFF)
    ) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .cancelar(cancelar),
        .limite(limite), .dado_mem(dado_mem), .endereco(endereco), .leds(leds),
        .ocupado(ocupado), .pronto(pronto), .db_estado(db_estado)
    );

    // Same-cycle RAM read.
    assign dado_mem = ram[endereco];

    // Clock / cycle counter
    always #5 clock = ~clock;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a run is just (start cycle, entry count); everything
    // else follows from the timing formulas.
    bit active    = 1'b0;
    int start_c   = 0;
    int n_ent     = 0;
    int hold_addr = 0;
    int pm_t;

    function automatic int model_addr(input int t);
        int off;
        off = t - 1 - PS;
        if (off < 0) return 0;
        if (off >= n_ent * P) return n_ent - 1;
        return off / P;
    endfunction

    always @(posedge clock) begin
        pm_t = cyc - start_c;
        if (!reset) begin
            active    = 1'b0;
            hold_addr = 0;
        end else if (active) begin
            if (cancelar) begin
                hold_addr = model_addr(pm_t);
                active    = 1'b0;
            end else if (pm_t - 1 - PS == n_ent * P) begin
                hold_addr = n_ent - 1;
                active    = 1'b0;
            end
        end else if (!cancelar && iniciar) begin
            active  = 1'b1;
            start_c = cyc;
            n_ent   = int'(limite) + 1;
        end
        cyc = cyc + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Scoreboard compare: every cycle after reset, DUT outputs vs the model.
    int e_leds, e_addr, e_oc, e_pr, e_db, cm_off, cm_i, cm_r;
    always @(negedge clock) begin
        if (chk_en) begin
            e_leds = 0; e_addr = hold_addr; e_oc = 0; e_pr = 0; e_db = 0;
            if (active) begin
                e_oc   = 1;
                cm_off = cyc - start_c - 1 - PS;
                if (cm_off < 0) begin
                    e_db = 6; e_addr = 0;
                end else if (cm_off < n_ent * P) begin
                    cm_i   = cm_off / P;
                    cm_r   = cm_off % P;
                    e_addr = cm_i;
                    if (cm_r == 0) e_db = 1;
                    else if (cm_r <= T_ON) begin
                        e_db = 2; e_leds = int'(ram[cm_i]);
                    end else if (cm_r <= T_ON + T_OFF) e_db = 3;
                    else e_db = 4;
                end else begin
                    e_db = 5; e_pr = 1; e_addr = n_ent - 1;
                end
            end
            check("model_leds", int'(leds), e_leds);
            check("model_endereco", int'(endereco), e_addr);
            check("model_ocupado", int'(ocupado), e_oc);
            check("model_pronto", int'(pronto), e_pr);
            check("model_db_estado", int'(db_estado), e_db);
        end
    end

    // Driver tasks: all driving happens at the falling edge of cycle cyc.
    task automatic at(input int target);
        while (cyc < target) @(negedge clock);
    endtask

    int c;
    int c2;

    task automatic go(input int lim);
        limite  = ADDR_W'(lim);
        iniciar = 1'b1;
        c       = cyc;
        at(cyc + 1);
        iniciar = 1'b0;
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; cancelar = 1'b0; limite = '0;
        for (int i = 0; i < 16; i++) ram[i] = DATA_W'(i);
        ram[0] = 4'd1; ram[1] = 4'd2; ram[2] = 4'd4; ram[3] = 4'd8;

        // Reset values
        at(2);
        chk_en = 1'b1;
        check("rst_leds", int'(leds), 0);
        check("rst_endereco", int'(endereco), 0);
        check("rst_ocupado", int'(ocupado), 0);
        check("rst_pronto", int'(pronto), 0);
        check("rst_db_estado", int'(db_estado), 0);
        reset = 1'b1;
        at(4);

        // Normal run
        go(3);
        at(c + 1);       check("norm_db_first", int'(db_estado), (PS > 0) ? 6 : 1);
        at(c + PS + 2);  check("norm_leds_c2", int'(leds), 1);
        at(c + PS + 5);  check("norm_leds_c5", int'(leds), 1);
        at(c + PS + 6);  check("norm_leds_c6", int'(leds), 0);
        at(c + PS + 10); check("norm_leds_c10", int'(leds), 2);
        at(c + PS + 21); check("norm_leds_c21", int'(leds), 4);
        at(c + PS + 26); check("norm_leds_c26", int'(leds), 8);
        at(c + PS + 32); check("norm_pronto_c32", int'(pronto), 0);
                         check("norm_ocupado_c32", int'(ocupado), 1);
        at(c + PS + 33); check("norm_pronto_c33", int'(pronto), 1);
                         check("norm_end_c33", int'(endereco), 3);
        at(c + PS + 34); check("norm_pronto_c34", int'(pronto), 0);
                         check("norm_ocupado_c34", int'(ocupado), 0);

        // Single entry
        at(cyc + 2);
        ram[0] = 4'b0010;
        go(0);
        at(c + PS + 2);  check("one_leds_c2", int'(leds), 2);
        at(c + PS + 9);  check("one_pronto_c9", int'(pronto), 1);
                         check("one_end_c9", int'(endereco), 0);
        at(c + PS + 11); check("one_end_idle", int'(endereco), 0);

        // Abort, then fresh replay from address 0
        ram[0] = 4'd1;
        go(3);
        at(c + 12); cancelar = 1'b1;
        at(c + 13); cancelar = 1'b0;
        check("abort_leds", int'(leds), 0);
        check("abort_ocupado", int'(ocupado), 0);
        at(c + 20); iniciar = 1'b1; limite = 4'd3; c2 = c + 20;
        at(c + 21); iniciar = 1'b0;
        at(c2 + PS + 2);  check("replay_leds_c2", int'(leds), 1);
                          check("replay_end_c2", int'(endereco), 0);
        at(c2 + PS + 33); check("replay_pronto", int'(pronto), 1);
        at(c2 + PS + 35);

        // Ignored iniciar and limite changes mid-run
        go(3);
        at(c + 3);  limite = 4'd1;
        at(c + 7);  iniciar = 1'b1;
        at(c + 8);  iniciar = 1'b0;
        at(c + PS + 33); check("ign_pronto_c33", int'(pronto), 1);
                         check("ign_end_c33", int'(endereco), 3);
        at(c + PS + 35);

        // Full address range: last entry at 2^ADDR_W-1, no wrap
        go(15);
        at(c + PS + 1 + 16 * P); check("full_pronto", int'(pronto), 1);
                                 check("full_end", int'(endereco), 15);
        at(c + PS + 3 + 16 * P); check("full_end_hold", int'(endereco), 15);

        // Reset mid-run
        go(2);
        at(c + 5); reset = 1'b0;
        at(c + 6); reset = 1'b1;
        check("rstrun_ocupado", int'(ocupado), 0);
        check("rstrun_end", int'(endereco), 0);
        at(c + 40);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
